dma_arbiter: RTL

Shared DMA engine and arbiter for the processors' memory-agent port. Each processor raises `ma_request` with `MA_WHAT` (source address in its local data segment), `MA_WHERE` (destination address in shared memory) and `MA_COUNT` (word count). The block grants one requester at a time in round-robin order and streams the words from that processor's data-segment read port into the shared-memory write port. It then returns the transferred word count on `MA_ANSWER` with a one-cycle `ma_answer` pulse.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_arbiter_rr.sv | 33 +++
 rtl/dma_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// dma_arbiter shared types and defaults.
// Imported by the arbiter and the DMA top level.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } dma_state_t;

  localparam int DMA_N_REQ = 2;
  localparam int DMA_AW    = 16;
  localparam int DMA_DW    = 16;
  localparam int DMA_CW    = 16;

endpackage

// File: rtl/dma_arbiter_rr.sv
// Combinational round-robin pick.
// First eligible index at or after ptr wins.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] c;

  // scan from ptr, wrapping, keep the first hit
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int k = 0; k < N; k++) begin
      c = PW'((int'(ptr) + k) % N);
      if (!any && elig[c]) begin
        any    = 1'b1;
        idx    = c;
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// Shared DMA engine: round-robin grant, then copy
// count words from local data segment to shared memory.
module dma_arbiter
  import dma_pkg::*;
#(
  parameter int N_REQ = DMA_N_REQ,
  parameter int AW    = DMA_AW,
  parameter int DW    = DMA_DW
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] what,
  input  logic [N_REQ*AW-1:0] where,
  input  logic [N_REQ*16-1:0] count,
  output logic [N_REQ-1:0]    ans_valid,
  output logic [15:0]         answer,
  output logic [AW-1:0]       mem_addr,
  input  logic [N_REQ*DW-1:0] mem_data,
  output logic [AW-1:0]       shm_addr,
  output logic [DW-1:0]       shm_wdata,
  output logic                shm_we,
  output logic [N_REQ-1:0]    grant,
  output logic                busy
);

  localparam int PW = $clog2(N_REQ);

  dma_state_t state;
  dma_state_t state_nxt;

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] arb_gnt;
  logic [N_REQ-1:0] mask_set;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    arb_idx;
  logic [PW-1:0]    owner;
  logic             arb_any;

  logic [AW-1:0] what_l;
  logic [AW-1:0] where_l;
  logic [AW-1:0] what_sel;
  logic [AW-1:0] where_sel;
  logic [15:0]   cnt_l;
  logic [15:0]   cnt_sel;
  logic [15:0]   i_cnt;
  logic [15:0]   j_cnt;
  logic          xfer_end;

  // a stale request stays masked until req drops
  assign elig = req & ~mask;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .elig (elig),
    .ptr  (ptr),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign what_sel  = what[arb_idx*AW +: AW];
  assign where_sel = where[arb_idx*AW +: AW];
  assign cnt_sel   = count[arb_idx*16 +: 16];
  assign xfer_end  = (j_cnt == cnt_l);
  assign mask_set  = (state == DONE) ? grant : '0;

  assign ptr_nxt = (owner == PW'(N_REQ - 1)) ?
                   '0 : owner + 1'b1;

  // state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (arb_any)
          state_nxt = (cnt_sel == '0) ? DONE : XFER;
      XFER:
        if (xfer_end) state_nxt = DONE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // registered outputs, job arguments and counters
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mask      <= '0;
      ptr       <= '0;
      owner     <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      ans_valid <= '0;
      answer    <= '0;
      mem_addr  <= '0;
      shm_addr  <= '0;
      shm_wdata <= '0;
      shm_we    <= 1'b0;
      what_l    <= '0;
      where_l   <= '0;
      cnt_l     <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
    end else begin
      ans_valid <= '0;
      shm_we    <= 1'b0;
      mask      <= (mask | mask_set) & req;
      case (state)
        IDLE: begin
          if (arb_any) begin
            owner   <= arb_idx;
            grant   <= arb_gnt;
            busy    <= 1'b1;
            what_l  <= what_sel;
            where_l <= where_sel;
            cnt_l   <= cnt_sel;
            i_cnt   <= 16'd1;
            j_cnt   <= '0;
            if (cnt_sel == '0) begin
              ans_valid <= arb_gnt;
              answer    <= '0;
            end else begin
              mem_addr <= what_sel;
            end
          end
        end
        XFER: begin
          if (i_cnt < cnt_l) begin
            mem_addr <= what_l + AW'(i_cnt);
            i_cnt    <= i_cnt + 16'd1;
          end
          if (!xfer_end) begin
            shm_we    <= 1'b1;
            shm_addr  <= where_l + AW'(j_cnt);
            shm_wdata <= mem_data[owner*DW +: DW];
            j_cnt     <= j_cnt + 16'd1;
          end else begin
            ans_valid <= grant;
            answer    <= cnt_l;
          end
        end
        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= ptr_nxt;
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
